// File: rtl/maxpool2d_if.sv
// maxpool2d_if: start/busy/done handshake plus flat input and pooled output maps
// (MAXPOOL_ARGMAX_EN adds the per-output winning-tap map)
interface maxpool2d_if #(
  parameter int N_IN  = 2704,
  parameter int N_OUT = 676,
  parameter int BITS  = 31
`ifdef MAXPOOL_ARGMAX_EN
  ,
  parameter int TW    = 2
`endif
);
  logic start;
  logic busy;
  logic done;
  logic signed [BITS:0] data_in  [N_IN];
  logic signed [BITS:0] data_out [N_OUT];
`ifdef MAXPOOL_ARGMAX_EN
  logic [TW-1:0] argmax [N_OUT];
  modport master (output start, data_in, input busy, done, data_out, argmax);
  modport slave  (input start, data_in, output busy, done, data_out, argmax);
`else
  modport master (output start, data_in, input busy, done, data_out);
  modport slave  (input start, data_in, output busy, done, data_out);
`endif
endinterface

// File: rtl/maxpool2d.sv
// maxpool2d: sequential POOLxPOOL max-pooling over CH parallel Q16.16 channels
// (define MAXPOOL_ARGMAX_EN to also publish the winning tap per output)
module maxpool2d #(
  parameter int IN_H   = 26,
  parameter int IN_W   = 26,
  parameter int CH     = 4,
  parameter int POOL   = 2,
  parameter int STRIDE = 2,
  parameter int OUT_H  = (IN_H - POOL) / STRIDE + 1,
  parameter int OUT_W  = (IN_W - POOL) / STRIDE + 1,
  parameter int BITS   = 31
) (
  input logic clk,
  input logic rstn,
  maxpool2d_if.slave bus
);
  localparam int NT  = POOL * POOL;
  localparam int NP  = OUT_H * OUT_W;
  localparam int NI  = IN_H * IN_W;
  localparam int TW  = NT > 1 ? $clog2(NT) : 1;
  localparam int PW  = NP > 1 ? $clog2(NP) : 1;
  localparam int AW  = NI * CH > 1 ? $clog2(NI * CH) : 1;
  localparam int OAW = NP * CH > 1 ? $clog2(NP * CH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_STORE = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] pos, orow, ocol;
  logic [TW-1:0] tap, pr, pc;
  logic [AW-1:0] base;
  logic signed [BITS:0] val [CH];
  logic signed [BITS:0] mx [CH];
`ifdef MAXPOOL_ARGMAX_EN
  logic [TW-1:0] arg [CH];
`endif
  assign bus.busy = state != S_IDLE;
  // orow/ocol and pr/pc track pos and tap incrementally so no divider is needed
  always_comb begin
    base = AW'((int'(orow) * STRIDE + int'(pr)) * IN_W + int'(ocol) * STRIDE + int'(pc));
    for (int c = 0; c < CH; c++) val[c] = bus.data_in[base + AW'(c * NI)];
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      bus.done <= 1'b0;
      pos      <= '0;
      orow     <= '0;
      ocol     <= '0;
      tap      <= '0;
      pr       <= '0;
      pc       <= '0;
      for (int c = 0; c < CH; c++) mx[c] <= '0;
      for (int i = 0; i < NP * CH; i++) bus.data_out[i] <= '0;
`ifdef MAXPOOL_ARGMAX_EN
      for (int c = 0; c < CH; c++) arg[c] <= '0;
      for (int i = 0; i < NP * CH; i++) bus.argmax[i] <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          state <= S_SCAN;
          pos   <= '0;
          orow  <= '0;
          ocol  <= '0;
          tap   <= '0;
          pr    <= '0;
          pc    <= '0;
        end
      end else if (state == S_SCAN) begin
        // strict compare keeps the earliest tap on ties
        for (int c = 0; c < CH; c++)
          if (tap == '0 || val[c] > mx[c]) begin
            mx[c]  <= val[c];
`ifdef MAXPOOL_ARGMAX_EN
            arg[c] <= tap;
`endif
          end
        if (tap == TW'(NT - 1)) state <= S_STORE;
        else begin
          tap <= tap + 1'b1;
          pc  <= pc == TW'(POOL - 1) ? '0 : pc + 1'b1;
          pr  <= pc == TW'(POOL - 1) ? pr + 1'b1 : pr;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          bus.data_out[OAW'(c * NP) + OAW'(pos)] <= mx[c];
`ifdef MAXPOOL_ARGMAX_EN
          bus.argmax[OAW'(c * NP) + OAW'(pos)]   <= arg[c];
`endif
        end
        if (pos == PW'(NP - 1)) begin
          state    <= S_IDLE;
          bus.done <= 1'b1;
        end else begin
          state <= S_SCAN;
          pos   <= pos + 1'b1;
          tap   <= '0;
          pr    <= '0;
          pc    <= '0;
          ocol  <= ocol == PW'(OUT_W - 1) ? '0 : ocol + 1'b1;
          orow  <= ocol == PW'(OUT_W - 1) ? orow + 1'b1 : orow;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool2d.sv
// tb_maxpool2d: directed checks of maxpool2d (26x26x4 default instance plus a 5x5x1 instance)
module tb_maxpool2d;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0, errors = 0, bcnt = 0, n = 0, seen = 0;
  always #5 clk = ~clk;

`ifdef MAXPOOL_ARGMAX_EN
  maxpool2d_if #(.N_IN(2704), .N_OUT(676), .BITS(31), .TW(2)) m();
  maxpool2d_if #(.N_IN(25), .N_OUT(4), .BITS(31), .TW(2)) s();
`else
  maxpool2d_if #(.N_IN(2704), .N_OUT(676), .BITS(31)) m();
  maxpool2d_if #(.N_IN(25), .N_OUT(4), .BITS(31)) s();
`endif
  maxpool2d dut (.clk(clk), .rstn(rstn), .bus(m));
  maxpool2d #(.IN_H(5), .IN_W(5), .CH(1)) sdut (.clk(clk), .rstn(rstn), .bus(s));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_main;
    m.start = 1'b1;
    tick;
    m.start = 1'b0;
  endtask

  task automatic wait_main(input int from, output int cnt);
    cnt = from;
    while (!m.done && cnt < 2000) begin
      tick;
      cnt++;
      if (m.busy) bcnt++;
    end
  endtask

  initial begin
    m.start = 1'b0;
    s.start = 1'b0;
    for (int i = 0; i < 2704; i++) m.data_in[i] = '0;
    for (int i = 0; i < 25; i++) s.data_in[i] = '0;
    tick;
    tick;
    check("rst_busy", 32'(m.busy), 32'd0);
    check("rst_done", 32'(m.done), 32'd0);
    check("rst_out0", m.data_out[0], 32'd0);
    check("rst_out675", m.data_out[675], 32'd0);
    rstn = 1'b1;
    tick;

    for (int i = 0; i < 2704; i++) m.data_in[i] = 32'(i) << 16;
    pulse_main;
    bcnt = m.busy ? 1 : 0;
    wait_main(0, n);
    check("ramp_latency", n, 845);
    check("ramp_busy_span", bcnt, 845);
    check("ramp_busy_low_at_done", 32'(m.busy), 32'd0);
    check("ramp_out0", m.data_out[0], 32'(27) << 16);
    check("ramp_out1", m.data_out[1], 32'(29) << 16);
    check("ramp_out168", m.data_out[168], 32'(675) << 16);
    check("ramp_out169", m.data_out[169], 32'(703) << 16);
    check("ramp_out675", m.data_out[675], 32'(2703) << 16);
`ifdef MAXPOOL_ARGMAX_EN
    check("ramp_arg0", 32'(m.argmax[0]), 32'd3);
`endif

    // new data and start during the done cycle
    for (int i = 0; i < 2704; i++) m.data_in[i] = 32'hFFFF0000;
    m.data_in[1352] = 32'hFFFD0000;
    m.data_in[1353] = 32'hFFFF8000;
    m.data_in[1378] = 32'hFFFF8000;
    m.data_in[1379] = 32'hFFFE0000;
    pulse_main;
    check("b2b_done_pulse", 32'(m.done), 32'd0);
    check("b2b_busy", 32'(m.busy), 32'd1);
    wait_main(0, n);
    check("b2b_latency", n, 845);
    check("neg_ch2_pos0", m.data_out[338], 32'hFFFF8000);
    check("neg_out0", m.data_out[0], 32'hFFFF0000);
    check("neg_out339", m.data_out[339], 32'hFFFF0000);
    check("neg_out675", m.data_out[675], 32'hFFFF0000);
`ifdef MAXPOOL_ARGMAX_EN
    check("neg_arg338", 32'(m.argmax[338]), 32'd1);
`endif
    tick;
    check("done_one_cycle", 32'(m.done), 32'd0);

    pulse_main;
    repeat (9) tick;
    pulse_main;
    wait_main(10, n);
    check("ignore_restart_latency", n, 845);
    tick;

    pulse_main;
    repeat (399) tick;
    rstn = 1'b0;
    tick;
    check("midrst_busy", 32'(m.busy), 32'd0);
    check("midrst_done", 32'(m.done), 32'd0);
    check("midrst_out0", m.data_out[0], 32'd0);
    check("midrst_out338", m.data_out[338], 32'd0);
`ifdef MAXPOOL_ARGMAX_EN
    check("midrst_arg338", 32'(m.argmax[338]), 32'd0);
`endif
    rstn = 1'b1;
    seen = 0;
    repeat (900) begin
      tick;
      if (m.done) seen++;
    end
    check("midrst_no_done", seen, 0);

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s.data_in[r * 5 + c] = (r == 4 || c == 4) ? 32'(100) << 16 : 32'(r * 5 + c) << 16;
    s.start = 1'b1;
    tick;
    s.start = 1'b0;
    n = 0;
    while (!s.done && n < 200) begin
      tick;
      n++;
    end
    check("small_latency", n, 20);
    check("small_out0", s.data_out[0], 32'(6) << 16);
    check("small_out1", s.data_out[1], 32'(8) << 16);
    check("small_out2", s.data_out[2], 32'(16) << 16);
    check("small_out3", s.data_out[3], 32'(18) << 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
